hourglass_ctrl: RTL and testbench

HOURGLASS_CTRL -- requirements
Module: hourglass_ctrl

---
 rtl/hourglass_pkg.sv | 16 +
 rtl/hourglass_ctrl_debounce.sv | 46 ++++
 rtl/hourglass_ctrl.sv | 104 ++++++++++
 tb/tb_hourglass_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/hourglass_pkg.sv
// Shared constants for the hourglass controller: run length, debounce window
// and the speed-select half-period table.
package hourglass_pkg;

    localparam int unsigned GRAINS_DEF = 20;
    localparam int unsigned DB_CYC_DEF = 20;
    localparam int unsigned REF_HZ     = 1000;

    // Half-periods in clk cycles at the 1 kHz reference clock, indexed by spd.
    localparam logic [8:0] HALF_TBL [4] = '{9'd62, 9'd125, 9'd250, 9'd500};

    function automatic logic [8:0] scale_half(input logic [8:0] h_ref, input int unsigned clk_hz);
        return 9'((32'(h_ref) * clk_hz) / REF_HZ);
    endfunction

endpackage

// File: rtl/hourglass_ctrl_debounce.sv
// Counter debouncer: the output follows the raw input only after the raw value
// has disagreed with it for DB_CYC consecutive cycles, plus one cycle to commit.
module debounce
    import hourglass_pkg::*;
#(
    parameter int unsigned DB_CYC     = DB_CYC_DEF,
    parameter bit          RST_TO_DIN = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int unsigned     CW      = $clog2(DB_CYC + 1);
    localparam logic [CW-1:0]   DB_LAST = CW'(DB_CYC);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          dout_q, dout_d;

    always_comb begin
        dout_d = dout_q;
        cnt_d  = '0;
        if (din != dout_q) begin
            if (cnt_q == DB_LAST) begin
                dout_d = din;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            // A level input (tilt switch) must not look like a change after reset.
            dout_q <= RST_TO_DIN ? din : 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/hourglass_ctrl.sv
// Hourglass timing controller: grain-step clock divider, grain counter,
// pause toggle and tilt-flip restart for the LED matrix stage.
module hourglass_ctrl
    import hourglass_pkg::*;
#(
    parameter int unsigned CLK_HZ = 1000,
    parameter int unsigned GRAINS = GRAINS_DEF,
    parameter int unsigned DB_CYC = DB_CYC_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw1_raw,
    input  logic       key_pause,
    input  logic [1:0] spd,
    output logic       clk_out,
    output logic [4:0] cnt,
    output logic       sw1,
    output logic       stop,
    output logic       done
);

    localparam logic [4:0] GRAINS_C = 5'(GRAINS);
    localparam logic [8:0] H_TBL [4] = '{scale_half(HALF_TBL[0], CLK_HZ),
                                         scale_half(HALF_TBL[1], CLK_HZ),
                                         scale_half(HALF_TBL[2], CLK_HZ),
                                         scale_half(HALF_TBL[3], CLK_HZ)};

    logic       key_db;
    logic       key_prev_q, sw1_prev_q;
    logic       pause_q, pause_d;
    logic [8:0] div_q, div_d;
    logic       clk_out_q, clk_out_d;
    logic [4:0] cnt_q, cnt_d;
    logic [8:0] h_m1;
    logic       press, flip;

    debounce #(.DB_CYC(DB_CYC), .RST_TO_DIN(1'b0)) u_db_key (
        .clk  (clk),
        .rst  (rst),
        .din  (key_pause),
        .dout (key_db)
    );

    debounce #(.DB_CYC(DB_CYC), .RST_TO_DIN(1'b1)) u_db_sw1 (
        .clk  (clk),
        .rst  (rst),
        .din  (sw1_raw),
        .dout (sw1)
    );

    assign h_m1  = H_TBL[spd] - 9'd1;
    assign press = key_db & ~key_prev_q;
    assign flip  = sw1 ^ sw1_prev_q;
    assign done  = (cnt_q == GRAINS_C);
    assign stop  = pause_q | done;

    always_comb begin
        pause_d   = pause_q;
        div_d     = div_q;
        clk_out_d = clk_out_q;
        cnt_d     = cnt_q;
        if (press) begin
            pause_d = ~pause_q;
        end
        // A flip restarts the run regardless of stop; pause is left alone.
        if (flip) begin
            div_d     = '0;
            clk_out_d = 1'b0;
            cnt_d     = '0;
        end else if (!stop) begin
            if (div_q >= h_m1) begin
                div_d     = '0;
                clk_out_d = ~clk_out_q;
                if (clk_out_q && (cnt_q < GRAINS_C)) begin
                    cnt_d = cnt_q + 5'd1;
                end
            end else begin
                div_d = div_q + 9'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pause_q    <= 1'b0;
            div_q      <= '0;
            clk_out_q  <= 1'b0;
            cnt_q      <= '0;
            key_prev_q <= 1'b0;
            sw1_prev_q <= sw1_raw;
        end else begin
            pause_q    <= pause_d;
            div_q      <= div_d;
            clk_out_q  <= clk_out_d;
            cnt_q      <= cnt_d;
            key_prev_q <= key_db;
            sw1_prev_q <= sw1;
        end
    end

    assign clk_out = clk_out_q;
    assign cnt     = cnt_q;

endmodule

// File: tb/tb_hourglass_ctrl.sv
// Bench for hourglass_ctrl: cycle-by-cycle behavioural model plus directed
// scenarios with hand-computed timing points.
module tb_hourglass_ctrl;

    localparam int unsigned GR = 20;
    localparam int unsigned DB = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sw1_raw = 1'b0;
    logic       key_pause = 1'b0;
    logic [1:0] spd = 2'd0;
    logic       clk_out, sw1, stop, done;
    logic [4:0] cnt;

    int n_pass = 0;
    int n_total = 0;
    bit chk_en = 1'b0;

    hourglass_ctrl #(.CLK_HZ(1000), .GRAINS(GR), .DB_CYC(DB)) dut (
        .clk       (clk),
        .rst       (rst),
        .sw1_raw   (sw1_raw),
        .key_pause (key_pause),
        .spd       (spd),
        .clk_out   (clk_out),
        .cnt       (cnt),
        .sw1       (sw1),
        .stop      (stop),
        .done      (done)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    function automatic int half_of(input logic [1:0] s);
        case (s)
            2'd0:    return 62;
            2'd1:    return 125;
            2'd2:    return 250;
            default: return 500;
        endcase
    endfunction

    logic m_key, m_key_last, m_sw, m_sw_last, m_pause, m_level;
    int   m_key_streak, m_sw_streak, m_elapsed, m_grains;

    // An input is accepted once DB+1 consecutive samples disagree with the accepted value.
    always @(posedge clk) begin
        if (rst) begin
            m_key <= 1'b0; m_key_last <= 1'b0; m_key_streak <= 0;
            m_sw <= sw1_raw; m_sw_last <= sw1_raw; m_sw_streak <= 0;
            m_pause <= 1'b0; m_level <= 1'b0; m_elapsed <= 0; m_grains <= 0;
        end else begin
            if (key_pause == m_key) m_key_streak <= 0;
            else if (m_key_streak + 1 == DB + 1) begin m_key <= key_pause; m_key_streak <= 0; end
            else m_key_streak <= m_key_streak + 1;
            if (sw1_raw == m_sw) m_sw_streak <= 0;
            else if (m_sw_streak + 1 == DB + 1) begin m_sw <= sw1_raw; m_sw_streak <= 0; end
            else m_sw_streak <= m_sw_streak + 1;
            m_key_last <= m_key;
            m_sw_last  <= m_sw;
            if (m_key && !m_key_last) m_pause <= !m_pause;
            if (m_sw != m_sw_last) begin
                m_elapsed <= 0; m_level <= 1'b0; m_grains <= 0;
            end else if (!(m_pause || m_grains == GR)) begin
                if (m_elapsed + 1 >= half_of(spd)) begin
                    m_elapsed <= 0;
                    m_level   <= !m_level;
                    if (m_level && m_grains < GR) m_grains <= m_grains + 1;
                end else begin
                    m_elapsed <= m_elapsed + 1;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
    endtask

    logic [8:0] exp_q[$];

    // Output vector {clk_out, cnt, sw1, stop, done} compared every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            exp_q.push_back({m_level, 5'(m_grains), m_sw, (m_pause || m_grains == GR), (m_grains == GR)});
            check("cycle_outputs", 32'({clk_out, cnt, sw1, stop, done}), 32'(exp_q.pop_front()));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    task automatic wait_cnt(input int target, input int budget);
        int i;
        i = 0;
        while (cnt != 5'(target) && i < budget) begin
            tick(1);
            i++;
        end
        check("wait_cnt", 32'(cnt), 32'(target));
    endtask

    task automatic wait_cnt_change(input int budget);
        logic [4:0] start;
        int i;
        start = cnt;
        i = 0;
        while (cnt == start && i < budget) begin
            tick(1);
            i++;
        end
        check("next_grain", 32'(cnt), 32'(start) + 32'd1);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        tick(2);
        chk_en = 1'b1;
        check("rst_cnt", 32'(cnt), 32'd0);
        check("rst_clk_out", 32'(clk_out), 32'd0);
        check("rst_stop_done", 32'({stop, done}), 32'd0);
        check("rst_sw1", 32'(sw1), 32'd0);
        rst = 1'b0;

        // Full run at spd=0: H=62, period 124, 20 grains in 2480 cycles.
        tick(61);   check("rise_at_61", 32'(clk_out), 32'd0);
        tick(1);    check("rise_at_62", 32'(clk_out), 32'd1);
        tick(62);   check("cnt1_at_124", 32'(cnt), 32'd1);
        tick(2355); check("done_at_2479", 32'(done), 32'd0);
        tick(1);    check("done_at_2480", 32'({done, stop, cnt}), 32'({1'b1, 1'b1, 5'd20}));
        tick(200);  check("frozen_after_done", 32'({clk_out, cnt}), 32'({1'b0, 5'd20}));

        // Tilt after done: sw1 follows after DB+1 cycles, flip the cycle after.
        sw1_raw = 1'b1;
        tick(20);   check("sw1_before_db", 32'(sw1), 32'd0);
        tick(1);    check("sw1_after_db", 32'(sw1), 32'd1);
        tick(1);    check("flip_clears", 32'({clk_out, cnt, done, stop}), 32'd0);
        tick(62);   check("flip_rise_62", 32'(clk_out), 32'd1);
        tick(2418); check("second_run_done", 32'({done, cnt}), 32'({1'b1, 5'd20}));

        // Pause press at cnt=5, then resume without skipping a grain.
        do_reset();
        wait_cnt(5, 1000);
        key_pause = 1'b1;
        tick(21);   check("pause_not_yet", 32'(stop), 32'd0);
        tick(1);    check("pause_stop", 32'({stop, cnt}), 32'({1'b1, 5'd5}));
        tick(3);    key_pause = 1'b0;
        tick(100);  check("paused_frozen", 32'({stop, cnt}), 32'({1'b1, 5'd5}));
        key_pause = 1'b1;
        tick(25);   key_pause = 1'b0;
        check("resumed", 32'(stop), 32'd0);
        wait_cnt_change(200);

        // Short glitches on both raw inputs must be rejected.
        for (int g = 0; g < 8; g++) begin
            key_pause = 1'b1; tick(5);
            key_pause = 1'b0; tick(3);
        end
        for (int g = 0; g < 8; g++) begin
            sw1_raw = 1'b0; tick(5);
            sw1_raw = 1'b1; tick(3);
        end
        tick(25);
        check("glitch_no_pause", 32'(stop), 32'd0);
        check("glitch_no_flip", 32'({sw1, (cnt >= 5'd6)}), 32'({1'b1, 1'b1}));

        // Speed change 3 -> 0 with div=300 toggles on the next cycle.
        spd = 2'd3;
        do_reset();
        tick(300);  check("slow_div300", 32'(clk_out), 32'd0);
        spd = 2'd0;
        tick(1);    check("spd_change_toggle", 32'(clk_out), 32'd1);
        tick(61);   check("fast_half_hold", 32'(clk_out), 32'd1);
        tick(1);    check("fast_half_62", 32'({clk_out, cnt}), 32'({1'b0, 5'd1}));

        // Reset in the same cycle as a flip at cnt=12: reset wins.
        do_reset();
        wait_cnt(12, 2000);
        sw1_raw = 1'b0;
        tick(21);   check("pre_flip_state", 32'({sw1, cnt}), 32'({1'b0, 5'd12}));
        rst = 1'b1;
        tick(1);    check("rst_over_flip", 32'({clk_out, cnt, sw1, stop, done}), 32'd0);
        rst = 1'b0;
        tick(61);   check("post_rst_low", 32'({clk_out, cnt}), 32'd0);
        tick(1);    check("post_rst_rise", 32'(clk_out), 32'd1);

        tick(5);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
